// File: rtl/piso_stream_pkg.sv
// piso_stream_pkg
//   Shared definitions for the parallel-in / serial-out streaming shifter:
//   the shifter FSM state type and the beat-counter width helper.
package piso_stream_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Beat counter width: enough bits to count 0..beats-1, never less than one.
  function automatic int cnt_width(input int beats);
    return (beats <= 1) ? 1 : $clog2(beats);
  endfunction

endpackage

// File: rtl/piso_delay.sv
// piso_delay
//   N-stage register pipeline carrying one serial beat plus its framing
//   flags ({valid, first, last, data}). N=0 is a pure pass-through.
//   All stages clear synchronously while rst_n is low, so a reset discards
//   every beat still travelling toward the pins.
// Ports:
//   clk        in   sole clock, rising edge
//   rst_n      in   synchronous active-low clear
//   in_valid   in   beat valid entering the pipeline
//   in_first   in   first-beat flag entering the pipeline
//   in_last    in   last-beat flag entering the pipeline
//   in_data    in   DW-bit beat entering the pipeline
//   out_valid  out  beat valid leaving the pipeline
//   out_first  out  first-beat flag leaving the pipeline
//   out_last   out  last-beat flag leaving the pipeline
//   out_data   out  DW-bit beat leaving the pipeline
//   any_valid  out  some stage currently holds a valid beat
module piso_delay #(
  parameter int DW = 1,
  parameter int N  = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic          in_first,
  input  logic          in_last,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic          out_first,
  output logic          out_last,
  output logic [DW-1:0] out_data,
  output logic          any_valid
);

  localparam int PW = DW + 3;

  logic [PW-1:0] in_word;
  logic [PW-1:0] out_word;

  assign in_word = {in_valid, in_first, in_last, in_data};
  assign {out_valid, out_first, out_last, out_data} = out_word;

  if (N == 0) begin : g_pass
    // No stages: clock and clear are intentionally left unused here.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign out_word  = in_word;
    assign any_valid = 1'b0;
  end else begin : g_pipe
    // These stages are retiming flops toward the pins; they must stay
    // discrete registers rather than collapse into SRL/ALTSHIFT primitives.
    (* shreg_extract = "no", altera_attribute = "-name AUTO_SHIFT_REGISTER_RECOGNITION OFF" *)
    logic [PW-1:0] stage_q [N];
    logic [PW-1:0] stage_d [N];
    logic [N-1:0]  stage_valid;

    always_comb begin
      stage_d[0] = in_word;
      for (int i = 1; i < N; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end

    always_ff @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
        if (!rst_n) begin
          stage_q[i] <= '0;
        end else begin
          stage_q[i] <= stage_d[i];
        end
      end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_valid
      assign stage_valid[gi] = stage_q[gi][PW-1];
    end

    assign out_word  = stage_q[N-1];
    assign any_valid = |stage_valid;
  end

endmodule

// File: rtl/piso_stream.sv
// piso_stream
//   Parallel-in, serial-out shifter with a valid/ready load handshake,
//   LANES serial bits per beat, selectable bit order, first/last frame
//   markers and an optional EXTRA_BITS-stage output delay pipeline.
//   A frame of BEATS = WIDTH/LANES beats leaves at one beat per cycle;
//   a new word may be accepted on the last beat for gapless streaming.
// Ports:
//   clk        in   sole clock, rising edge
//   rst_n      in   synchronous active-low reset
//   s_valid    in   parallel word offered
//   s_ready    out  word can be accepted this cycle
//   s_data     in   WIDTH-bit parallel word
//   data_out   out  LANES-bit serial beat (0 outside valid beats)
//   out_valid  out  data_out carries frame data
//   out_first  out  first beat of a frame
//   out_last   out  last beat of a frame
//   busy       out  frame in shifter or delay pipeline
module piso_stream
  import piso_stream_pkg::*;
#(
  parameter int WIDTH      = 50,
  parameter int LANES      = 1,
  parameter int EXTRA_BITS = 0,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic [LANES-1:0] data_out,
  output logic             out_valid,
  output logic             out_first,
  output logic             out_last,
  output logic             busy
);

  if (WIDTH < 1 || LANES < 1 || EXTRA_BITS < 0 || (WIDTH % LANES) != 0) begin : g_bad_params
    $error("piso_stream: illegal WIDTH/LANES/EXTRA_BITS combination");
  end

  localparam int              BEATS     = WIDTH / LANES;
  localparam int              CW        = cnt_width(BEATS);
  localparam logic [CW-1:0]   LAST_BEAT = CW'(BEATS - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  (* shreg_extract = "no", altera_attribute = "-name AUTO_SHIFT_REGISTER_RECOGNITION OFF" *)
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;

  logic             accept;
  logic             beat_valid;
  logic             beat_first;
  logic             beat_last;
  logic [LANES-1:0] beat_data;

  logic             dly_valid;
  logic             dly_first;
  logic             dly_last;
  logic [LANES-1:0] dly_data;
  logic             dly_busy;

  // Ready depends only on state, never on s_valid, so it cannot form a
  // combinational loop with an upstream source that waits for ready.
  assign s_ready = rst_n && ((state_q == IDLE) ||
                             ((state_q == SHIFT) && (cnt_q == LAST_BEAT)));
  assign accept  = s_valid && s_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          shift_d = s_data;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == LAST_BEAT) begin
          cnt_d = '0;
          if (accept) begin
            shift_d = s_data;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d   = cnt_q + 1'b1;
          // The outgoing beat always sits at the end selected by bit order.
          shift_d = MSB_FIRST ? (shift_q << LANES) : (shift_q >> LANES);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    beat_valid = (state_q == SHIFT);
    beat_first = beat_valid && (cnt_q == '0);
    beat_last  = beat_valid && (cnt_q == LAST_BEAT);
    beat_data  = '0;
    if (beat_valid) begin
      beat_data = MSB_FIRST ? shift_q[WIDTH-1 -: LANES] : shift_q[LANES-1:0];
    end
  end

  piso_delay #(
    .DW (LANES),
    .N  (EXTRA_BITS)
  ) u_delay (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (beat_valid),
    .in_first  (beat_first),
    .in_last   (beat_last),
    .in_data   (beat_data),
    .out_valid (dly_valid),
    .out_first (dly_first),
    .out_last  (dly_last),
    .out_data  (dly_data),
    .any_valid (dly_busy)
  );

  // Hold the pins quiet for the whole time reset is asserted, not only
  // from the first reset edge onward.
  assign out_valid = rst_n && dly_valid;
  assign out_first = rst_n && dly_first;
  assign out_last  = rst_n && dly_last;
  assign data_out  = rst_n ? dly_data : '0;
  assign busy      = rst_n && ((state_q == SHIFT) || dly_busy);

endmodule

// File: tb/tb_piso_stream.sv
`timescale 1ns/1ps
module tb_piso_stream;

  localparam int NCFG = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  logic [NCFG-1:0] done_v;

  // Configurations: width, lanes, extra stages, bit order, directed words.
  function automatic int cfg_w(input int i);
    case (i)
      0: return 8;  1: return 8;  2: return 16;
      3: return 8;  4: return 12; default: return 4;
    endcase
  endfunction
  function automatic int cfg_l(input int i);
    case (i)
      0: return 1; 1: return 1; 2: return 4;
      3: return 2; 4: return 3; default: return 4;
    endcase
  endfunction
  function automatic int cfg_e(input int i);
    case (i)
      3: return 3; 4: return 2; default: return 0;
    endcase
  endfunction
  function automatic bit cfg_m(input int i);
    return (i == 1 || i == 3) ? 1'b0 : 1'b1;
  endfunction
  function automatic int cfg_ndir(input int i);
    return (i == 1 || i == 5) ? 2 : 1;
  endfunction
  function automatic int cfg_dir(input int i, input int j);
    case (i)
      0: return 32'hA5;
      1: return (j == 0) ? 32'h01 : 32'h80;
      2: return 32'h1234;
      3: return 32'h3C;
      4: return 32'hABC;
      default: return (j == 0) ? 32'hF : 32'h0;
    endcase
  endfunction

  task automatic check(input int g, input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40)
        $display("FAIL cfg%0d %s: got %0h, required %0h (cycle %0d)", g, name, act, exp, cyc);
    end
  endtask

  for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
    localparam int W     = cfg_w(gi);
    localparam int L     = cfg_l(gi);
    localparam int E     = cfg_e(gi);
    localparam bit M     = cfg_m(gi);
    localparam int BEATS = W / L;

    logic         rst_n;
    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] s_data;
    logic [L-1:0] data_out;
    logic         out_valid;
    logic         out_first;
    logic         out_last;
    logic         busy;

    // Scoreboard: expected beats {first,last,data} and the cycle each must
    // be on the pins.
    logic [L+1:0] q_beat[$];
    int           q_out[$];
    int           free_at   = 0;
    bit           exp_ready = 1'b0;
    bit           done      = 1'b0;

    assign done_v[gi] = done;

    piso_stream #(
      .WIDTH      (W),
      .LANES      (L),
      .EXTRA_BITS (E),
      .MSB_FIRST  (M)
    ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .data_out  (data_out),
      .out_valid (out_valid),
      .out_first (out_first),
      .out_last  (out_last),
      .busy      (busy)
    );

    // One cycle of stimulus plus the reference model of what it causes.
    // Model: the block takes a word whenever the previous frame is on its
    // last beat or gone; beat k of a word taken at the end of cycle n is on
    // the pins in cycle n+1+E+k, holding slice k of the word in bit order.
    task automatic drive_cycle(input bit v, input logic [W-1:0] d, input bit r);
      int idx;
      logic [L-1:0] b;
      @(posedge clk);
      #1;
      rst_n   = r;
      s_valid = v;
      s_data  = d;
      if (!r) begin
        q_beat.delete();
        q_out.delete();
        free_at   = 0;
        exp_ready = 1'b0;
      end else begin
        exp_ready = (cyc >= free_at);
        if (v && exp_ready) begin
          for (int k = 0; k < BEATS; k++) begin
            idx = M ? (BEATS - 1 - k) : k;
            b   = L'(d >> (idx * L));
            q_beat.push_back({(k == 0), (k == BEATS - 1), b});
            q_out.push_back(cyc + 1 + E + k);
          end
          free_at = cyc + BEATS;
          $display("cfg%0d accept data=%0h cycle=%0d", gi, d, cyc);
        end
      end
    endtask

    initial begin
      bit           v;
      logic [W-1:0] d;
      rst_n   = 1'b0;
      s_valid = 1'b0;
      s_data  = '0;
      repeat (3) drive_cycle(1'b0, '0, 1'b0);

      // Directed words offered back to back under continuous valid.
      for (int j = 0; j < cfg_ndir(gi); j++) begin
        do begin
          drive_cycle(1'b1, W'(cfg_dir(gi, j)), 1'b1);
        end while (!exp_ready);
      end
      repeat (BEATS + E + 2) drive_cycle(1'b0, '0, 1'b1);

      // Random traffic; an offered word is held until taken.
      v = 1'b0;
      d = '0;
      for (int c = 0; c < 300; c++) begin
        if (!v || exp_ready) begin
          v = ($urandom_range(0, 99) < 70);
          d = W'($urandom);
        end
        drive_cycle(v, d, 1'b1);
      end

      // Continuous valid: must stream gaplessly.
      d = W'($urandom);
      for (int c = 0; c < 4 * BEATS + 2; c++) begin
        drive_cycle(1'b1, d, 1'b1);
        if (exp_ready) d = W'($urandom);
      end

      // Reset while pin beat 3 of a frame is showing.
      do begin
        drive_cycle(1'b1, d, 1'b1);
      end while (!exp_ready);
      repeat (E + 3) drive_cycle(1'b0, '0, 1'b1);
      repeat (2) drive_cycle(1'b0, '0, 1'b0);
      drive_cycle(1'b1, W'($urandom), 1'b1);
      repeat (BEATS + E + 3) drive_cycle(1'b0, '0, 1'b1);

      // More random traffic after the reset, then drain.
      v = 1'b0;
      for (int c = 0; c < 100; c++) begin
        if (!v || exp_ready) begin
          v = ($urandom_range(0, 99) < 60);
          d = W'($urandom);
        end
        drive_cycle(v, d, 1'b1);
      end
      for (int c = 0; c < 200 && q_out.size() > 0; c++) drive_cycle(1'b0, '0, 1'b1);
      check(gi, "drain_left", 64'(q_out.size()), 64'd0);
      done = 1'b1;
    end

    // Monitor: compares pins against the scoreboard every falling edge.
    initial begin
      bit exp_busy;
      forever begin
        @(negedge clk);
        check(gi, "s_ready", 64'(s_ready), 64'(exp_ready));
        exp_busy = (q_out.size() > 0) && (q_out[0] - E <= cyc);
        check(gi, "busy", 64'(busy), 64'(exp_busy));
        if (q_out.size() > 0 && q_out[0] == cyc) begin
          check(gi, "out_valid", 64'(out_valid), 64'd1);
          check(gi, "beat{first,last,data}", 64'({out_first, out_last, data_out}), 64'(q_beat[0]));
          void'(q_out.pop_front());
          void'(q_beat.pop_front());
        end else begin
          check(gi, "out_valid", 64'(out_valid), 64'd0);
          check(gi, "idle{first,last,data}", 64'({out_first, out_last, data_out}), 64'd0);
        end
      end
    end
  end

  initial begin
    int waited;
    waited = 0;
    while (done_v !== '1 && waited < 20000) begin
      @(posedge clk);
      waited++;
    end
    if (done_v !== '1) begin
      total++;
      bad++;
      $display("FAIL timeout: done=%b, required all ones", done_v);
    end
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
